// File: rtl/dcache_pkg.sv
// Shared definitions for the N-way data-cache store: tag flag positions,
// flush engine states and index-width helpers.
package dcache_pkg;

  // Flag positions measured down from the tag MSB: valid at TAG_W-1, dirty at TAG_W-2.
  localparam int TAG_VALID_BIT = 1;
  localparam int TAG_DIRTY_BIT = 2;

  typedef enum logic [1:0] {
    FL_IDLE,
    FL_SCAN,
    FL_EMIT
  } flush_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int tag_valid_pos(input int tag_w);
    return tag_w - TAG_VALID_BIT;
  endfunction

  function automatic int tag_dirty_pos(input int tag_w);
    return tag_w - TAG_DIRTY_BIT;
  endfunction

endpackage

// File: rtl/dcache_lru_ages.sv
// True-LRU age vector for one cache set; the way holding age WAYS-1 is the
// replacement victim. Ages return to way-0-is-LRU on reset or clear_i.
module dcache_lru_ages
  import dcache_pkg::*;
#(
  parameter int WAYS = 2,
  parameter int AW   = idx_w(WAYS)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic                    touch_en,
  input  logic [AW-1:0]           touch_way,
  output logic [WAYS-1:0][AW-1:0] ages,
  output logic [AW-1:0]           lru_way
);

  if (WAYS == 1) begin : g_single
    assign ages    = '0;
    assign lru_way = '0;
  end else begin : g_multi
    logic [WAYS-1:0][AW-1:0] age_q, age_d;
    logic [AW-1:0]           old_age;

    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
      age_d   = age_q;
      old_age = age_q[touch_way];
      for (int w = 0; w < WAYS; w++) begin
        if (AW'(w) == touch_way)     age_d[w] = '0;
        else if (age_q[w] < old_age) age_d[w] = age_q[w] + AW'(1);
      end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk_i) begin
      if (!rst_ni || clear_i) begin
        for (int w = 0; w < WAYS; w++) age_q[w] <= AW'(WAYS - 1 - w);
      end else if (touch_en) begin
        age_q <= age_d;
      end
    end

    always_comb begin
      lru_way = '0;
      for (int w = 0; w < WAYS; w++) begin
        if (age_q[w] == AW'(WAYS - 1)) lru_way = AW'(w);
      end
    end

    assign ages = age_q;
  end

endmodule

// File: rtl/dcache_nway_sram.sv
// N-way set-associative dcache tag/data store with true-LRU, victim readout and
// a dirty-line flush engine. Optional per-line parity: define DCACHE_PARITY_EN.
module dcache_nway_sram
  import dcache_pkg::*;
#(
  parameter int SETS   = 16,
  parameter int WAYS   = 2,
  parameter int TAG_W  = 25,
  parameter int LINE_W = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    enable_i,
  input  logic                    write_i,
  input  logic [idx_w(SETS)-1:0]  addr_i,
  input  logic [TAG_W-1:0]        tag_i,
  input  logic [LINE_W-1:0]       data_i,
  output logic                    hit_o,
  output logic [idx_w(WAYS)-1:0]  hit_way_o,
  output logic [TAG_W-1:0]        tag_o,
  output logic [LINE_W-1:0]       data_o,
  output logic [TAG_W-1:0]        victim_tag_o,
  output logic [LINE_W-1:0]       victim_data_o,
  input  logic                    flush_i,
  output logic                    flush_busy_o,
  output logic                    flush_valid_o,
  input  logic                    flush_ready_i,
  output logic [idx_w(SETS)-1:0]  flush_set_o,
  output logic [TAG_W-1:0]        flush_tag_o,
  output logic [LINE_W-1:0]       flush_data_o,
  output logic                    parity_err_o
);

  localparam int SW = idx_w(SETS);
  localparam int WW = idx_w(WAYS);
  localparam int VB = tag_valid_pos(TAG_W);
  localparam int DB = tag_dirty_pos(TAG_W);
  localparam int AT = TAG_W - 3;

  logic [TAG_W-1:0]        tag_q  [SETS][WAYS];
  logic [LINE_W-1:0]       data_q [SETS][WAYS];
  logic [WW-1:0]           lru_way [SETS];
  logic [WAYS-1:0][WW-1:0] set_ages_unused [SETS];

  flush_state_e  state_q, state_d;
  logic [SW-1:0] cur_set_q;
  logic [WW-1:0] cur_way_q;
  logic          busy, cur_dirty, last_line, advance, flush_done;
  logic          look_hit, wr_en, touch_any;
  logic [WW-1:0] look_way, wr_way, touch_way;
  logic [SETS-1:0] touch_en;

  // Lowest matching way wins: scan downwards so the last assignment is the smallest index.
  always_comb begin
    look_hit = 1'b0;
    look_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (tag_q[addr_i][w][VB] && tag_q[addr_i][w][AT:0] == tag_i[AT:0]) begin
        look_hit = 1'b1;
        look_way = WW'(w);
      end
    end
  end

  assign busy      = (state_q != FL_IDLE);
  assign wr_en     = enable_i & write_i & ~busy;
  assign wr_way    = look_hit ? look_way : lru_way[addr_i];
  assign touch_any = enable_i & ~busy & (write_i | look_hit);
  assign touch_way = write_i ? wr_way : look_way;

  for (genvar s = 0; s < SETS; s++) begin : g_set
    assign touch_en[s] = touch_any && (addr_i == SW'(s));
    dcache_lru_ages #(.WAYS(WAYS)) u_ages (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .clear_i   (flush_done),
      .touch_en  (touch_en[s]),
      .touch_way (touch_way),
      .ages      (set_ages_unused[s]),
      .lru_way   (lru_way[s])
    );
  end

  assign hit_o         = look_hit & ~busy;
  assign hit_way_o     = hit_o ? look_way : '0;
  assign tag_o         = hit_o ? tag_q[addr_i][look_way] : '0;
  assign data_o        = hit_o ? data_q[addr_i][look_way] : '0;
  assign victim_tag_o  = tag_q[addr_i][lru_way[addr_i]];
  assign victim_data_o = data_q[addr_i][lru_way[addr_i]];

  assign cur_dirty  = tag_q[cur_set_q][cur_way_q][VB] & tag_q[cur_set_q][cur_way_q][DB];
  assign last_line  = (cur_set_q == SW'(SETS - 1)) && (cur_way_q == WW'(WAYS - 1));
  assign advance    = ((state_q == FL_SCAN) && !cur_dirty) || ((state_q == FL_EMIT) && flush_ready_i);
  assign flush_done = advance & last_line;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= FL_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FL_IDLE: if (flush_i) state_d = FL_SCAN;
      FL_SCAN: begin
        if (cur_dirty)      state_d = FL_EMIT;
        else if (last_line) state_d = FL_IDLE;
      end
      FL_EMIT: if (flush_ready_i) state_d = last_line ? FL_IDLE : FL_SCAN;
      default: state_d = FL_IDLE;
    endcase
  end

  always_comb begin
    flush_busy_o  = (state_q != FL_IDLE);
    flush_valid_o = (state_q == FL_EMIT);
    flush_set_o   = '0;
    flush_tag_o   = '0;
    flush_data_o  = '0;
    if (state_q == FL_EMIT) begin
      flush_set_o  = cur_set_q;
      flush_tag_o  = tag_q[cur_set_q][cur_way_q];
      flush_data_o = data_q[cur_set_q][cur_way_q];
    end
  end

  // Cursor walks set-major, way-minor and wraps back to (0,0) after the last line.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cur_set_q <= '0;
      cur_way_q <= '0;
    end else if (advance) begin
      if (int'(cur_way_q) == WAYS - 1) begin
        cur_way_q <= '0;
        cur_set_q <= cur_set_q + SW'(1);
      end else begin
        cur_way_q <= cur_way_q + WW'(1);
      end
    end
  end

  // NOTE: the arrays are reset explicitly because lookups must miss right after reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          tag_q[s][w]  <= '0;
          data_q[s][w] <= '0;
        end
      end
    end else begin
      if (wr_en) begin
        tag_q[addr_i][wr_way]  <= tag_i;
        data_q[addr_i][wr_way] <= data_i;
      end
      if (advance) begin
        tag_q[cur_set_q][cur_way_q][VB] <= 1'b0;
        tag_q[cur_set_q][cur_way_q][DB] <= 1'b0;
      end
    end
  end

`ifdef DCACHE_PARITY_EN
  logic par_q [SETS][WAYS];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) par_q[s][w] <= 1'b0;
      end
    end else if (wr_en) begin
      par_q[addr_i][wr_way] <= ^data_i;
    end
  end

  assign parity_err_o = hit_o && (par_q[addr_i][look_way] != ^data_o);
`else
  assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_dcache_nway_sram.sv
// Self-checking bench for dcache_nway_sram (4 ways): directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a behavioural model.
module tb_dcache_nway_sram;

  localparam int SETS   = 16;
  localparam int WAYS   = 4;
  localparam int TAG_W  = 25;
  localparam int LINE_W = 256;
  localparam int SW     = 4;
  localparam int WW     = 2;
  localparam int NLINES = SETS * WAYS;

  localparam logic [TAG_W-1:0] TAG_A  = {2'b10, 23'h11};
  localparam logic [TAG_W-1:0] TAG_B  = {2'b10, 23'h12};
  localparam logic [TAG_W-1:0] TAG_C  = {2'b10, 23'h13};
  localparam logic [TAG_W-1:0] TAG_D  = {2'b10, 23'h14};
  localparam logic [TAG_W-1:0] TAG_E  = {2'b10, 23'h15};
  localparam logic [TAG_W-1:0] TAG_C0 = {2'b10, 23'h21};
  localparam logic [TAG_W-1:0] TAG_D0 = {2'b11, 23'h22};
  localparam logic [TAG_W-1:0] TAG_D5 = {2'b11, 23'h51};
  localparam logic [TAG_W-1:0] TAG_77 = {2'b10, 23'h77};
  localparam logic [TAG_W-1:0] TAG_78 = {2'b10, 23'h78};

  logic              clk_i = 1'b0;
  logic              rst_ni, enable_i, write_i, flush_i, flush_ready_i;
  logic [SW-1:0]     addr_i;
  logic [TAG_W-1:0]  tag_i;
  logic [LINE_W-1:0] data_i;
  logic              hit_o, flush_busy_o, flush_valid_o, parity_err_o;
  logic [WW-1:0]     hit_way_o;
  logic [TAG_W-1:0]  tag_o, victim_tag_o, flush_tag_o;
  logic [LINE_W-1:0] data_o, victim_data_o, flush_data_o;
  logic [SW-1:0]     flush_set_o;

  dcache_nway_sram #(.SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W), .LINE_W(LINE_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .write_i(write_i),
    .addr_i(addr_i), .tag_i(tag_i), .data_i(data_i),
    .hit_o(hit_o), .hit_way_o(hit_way_o), .tag_o(tag_o), .data_o(data_o),
    .victim_tag_o(victim_tag_o), .victim_data_o(victim_data_o),
    .flush_i(flush_i), .flush_busy_o(flush_busy_o), .flush_valid_o(flush_valid_o),
    .flush_ready_i(flush_ready_i), .flush_set_o(flush_set_o), .flush_tag_o(flush_tag_o),
    .flush_data_o(flush_data_o), .parity_err_o(parity_err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [TAG_W-1:0]  m_tag  [SETS][WAYS];
  logic [LINE_W-1:0] m_data [SETS][WAYS];
  int                m_age  [SETS][WAYS];
  bit                m_busy, m_emit, m_ok;
  int                m_pos;

  function automatic int m_hit(input int s, input logic [TAG_W-1:0] t);
    for (int w = 0; w < WAYS; w++)
      if (m_tag[s][w][TAG_W-1] && m_tag[s][w][TAG_W-3:0] == t[TAG_W-3:0]) return w;
    return -1;
  endfunction

  function automatic int m_lru(input int s);
    for (int w = 0; w < WAYS; w++) if (m_age[s][w] == WAYS - 1) return w;
    return 0;
  endfunction

  task automatic m_ages_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) m_age[s][w] = WAYS - 1 - w;
  endtask

  task automatic m_touch(input int s, input int w);
    int old;
    old = m_age[s][w];
    for (int v = 0; v < WAYS; v++) begin
      if (v == w)                m_age[s][v] = 0;
      else if (m_age[s][v] < old) m_age[s][v] = m_age[s][v] + 1;
    end
  endtask

  task automatic m_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_tag[s][w]  = '0;
        m_data[s][w] = '0;
      end
    m_ages_reset();
    m_busy = 0; m_emit = 0; m_pos = 0;
  endtask

  initial begin
    m_ok = 0;
    forever begin
      @(posedge clk_i);
      if (!rst_ni) begin
        m_reset();
        m_ok = 1;
      end else if (m_ok) begin
        if (!m_busy && enable_i) begin
          int s, hw, w;
          s  = int'(addr_i);
          hw = m_hit(s, tag_i);
          if (write_i) begin
            w = (hw >= 0) ? hw : m_lru(s);
            m_tag[s][w]  = tag_i;
            m_data[s][w] = data_i;
            m_touch(s, w);
          end else if (hw >= 0) begin
            m_touch(s, hw);
          end
        end
        if (m_busy) begin
          int s, w;
          s = m_pos / WAYS;
          w = m_pos % WAYS;
          if (!m_emit && m_tag[s][w][TAG_W-1] && m_tag[s][w][TAG_W-2]) begin
            m_emit = 1;
          end else if (!m_emit || flush_ready_i) begin
            m_tag[s][w][TAG_W-1] = 1'b0;
            m_tag[s][w][TAG_W-2] = 1'b0;
            m_emit = 0;
            if (m_pos == NLINES - 1) begin
              m_busy = 0;
              m_pos  = 0;
              m_ages_reset();
            end else begin
              m_pos++;
            end
          end
        end else if (flush_i) begin
          m_busy = 1;
          m_pos  = 0;
          m_emit = 0;
        end
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  initial forever begin
    @(negedge clk_i);
    if (m_ok && rst_ni) begin
      int s, hw, vw, fs, fw;
      bit eh;
      s  = int'(addr_i);
      hw = m_hit(s, tag_i);
      eh = !m_busy && (hw >= 0);
      vw = m_lru(s);
      check("hit", hit_o, eh);
      check("hit_way", hit_way_o, eh ? hw : 0);
      check("tag_out", tag_o, eh ? m_tag[s][hw] : '0);
      check("data_out", data_o, eh ? m_data[s][hw] : '0);
      check("victim_tag", victim_tag_o, m_tag[s][vw]);
      check("victim_data", victim_data_o, m_data[s][vw]);
      check("busy", flush_busy_o, m_busy);
      check("flush_valid", flush_valid_o, m_busy && m_emit);
      check("parity_err", parity_err_o, 0);
      for (int w = 0; w < WAYS; w++) check("age", dut.set_ages_unused[s][w], m_age[s][w]);
      if (m_busy && m_emit) begin
        fs = m_pos / WAYS;
        fw = m_pos % WAYS;
        check("flush_set", flush_set_o, fs);
        check("flush_tag", flush_tag_o, m_tag[fs][fw]);
        check("flush_data", flush_data_o, m_data[fs][fw]);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input bit en, input bit wr, input int s, input logic [TAG_W-1:0] t,
                       input logic [LINE_W-1:0] d);
    enable_i = en;
    write_i  = wr;
    addr_i   = SW'(s);
    tag_i    = t;
    data_i   = d;
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] r;
    for (int i = 0; i < LINE_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic do_reset();
    rst_ni = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LINE_W-1:0] d_dead, d_e, d_d0, d_d5;
    logic [TAG_W-1:0]  tags [4];
    int busy_cnt, stall, cyc;
    bit started;
    int emitted[$];

    d_dead = {8{32'hDEADBEEF}};
    tags[0] = TAG_A; tags[1] = TAG_B; tags[2] = TAG_C; tags[3] = TAG_D;
    rst_ni = 1'b0; flush_i = 1'b0; flush_ready_i = 1'b0;
    drive(0, 0, 0, '0, '0);
    do_reset();

    // Reset state: everything misses, way 0 is LRU.
    drive(0, 0, 3, 25'h1000005, '0);
    @(negedge clk_i);
    check("rst_hit", hit_o, 0);
    check("rst_data", data_o, 0);
    check("rst_victim_tag", victim_tag_o, 0);
    check("rst_age_way0", dut.set_ages_unused[3][0], 3);
    check("rst_busy", flush_busy_o, 0);
    tick();

    // Fill set 2 with A..D, read A, then E must evict B in way 1.
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 2, tags[i], rand_line());
      tick();
    end
    drive(1, 0, 2, TAG_A, '0);
    @(negedge clk_i);
    check("readA_hit", hit_o, 1);
    check("readA_way", hit_way_o, 0);
    tick();
    d_e = rand_line();
    drive(1, 1, 2, TAG_E, d_e);
    @(negedge clk_i);
    check("fillE_victim_is_B", victim_tag_o, TAG_B);
    tick();
    drive(0, 0, 2, TAG_E, '0);
    @(negedge clk_i);
    check("E_in_way1", hit_way_o, 1);
    check("E_data", data_o, d_e);
    tick();
    drive(0, 0, 2, TAG_B, '0);
    @(negedge clk_i);
    check("B_evicted", hit_o, 0);
    tick();

    // Read A (way 0 -> age 0), then write-hit E in way 1: way1 -> 0, way0 ages to 1.
    drive(1, 0, 2, TAG_A, '0);
    tick();
    drive(1, 1, 2, TAG_E, d_dead);
    tick();
    drive(0, 0, 2, TAG_E, '0);
    @(negedge clk_i);
    check("wrhit_data", data_o, d_dead);
    check("wrhit_age_way1", dut.set_ages_unused[2][1], 0);
    check("wrhit_age_way0", dut.set_ages_unused[2][0], 1);
    tick();

    // Flush with two dirty lines and a 3-cycle stall on the first.
    do_reset();
    d_d0 = rand_line();
    d_d5 = rand_line();
    drive(1, 1, 0, TAG_C0, rand_line()); tick();
    drive(1, 1, 0, TAG_D0, d_d0);        tick();
    drive(1, 1, 5, TAG_D5, d_d5);        tick();
    drive(0, 0, 0, TAG_D0, '0);
    flush_ready_i = 1'b0;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    busy_cnt = 0; stall = 0; started = 0; cyc = 0;
    emitted.delete();
    while (cyc < 300 && !(started && !flush_busy_o)) begin
      @(negedge clk_i);
      cyc++;
      if (flush_busy_o) begin
        started = 1;
        busy_cnt++;
      end
      if (flush_valid_o && emitted.size() == 0 && stall < 3) begin
        check("stall_set", flush_set_o, 0);
        check("stall_tag", flush_tag_o, TAG_D0);
        check("stall_data", flush_data_o, d_d0);
        flush_ready_i = 1'b0;
        stall++;
      end else if (flush_valid_o) begin
        flush_ready_i = 1'b1;
        emitted.push_back(int'(flush_set_o));
      end else begin
        flush_ready_i = 1'b0;
      end
    end
    check("flush_terminated", started && !flush_busy_o, 1);
    check("flush_busy_cycles", busy_cnt, NLINES + 2 + 3);
    check("flush_emit_count", emitted.size(), 2);
    if (emitted.size() == 2) begin
      check("flush_first_set", emitted[0], 0);
      check("flush_second_set", emitted[1], 5);
    end
    flush_ready_i = 1'b0;
    tick();
    drive(0, 0, 0, TAG_D0, '0);
    @(negedge clk_i);
    check("post_flush_miss_d0", hit_o, 0);
    tick();
    drive(0, 0, 5, TAG_D5, '0);
    @(negedge clk_i);
    check("post_flush_miss_d5", hit_o, 0);
    tick();

    // Accesses during flush are ignored.
    drive(1, 1, 7, TAG_77, rand_line());
    tick();
    drive(0, 0, 7, TAG_77, '0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 7, (i % 2 == 0) ? TAG_77 : TAG_78, rand_line());
      @(negedge clk_i);
      if (i % 2 == 0) check("busy_hit_blocked", hit_o, 0);
      else            check("busy_write_blocked", victim_data_o, '0);
      tick();
    end
    drive(0, 0, 7, TAG_78, '0);
    cyc = 0;
    while (flush_busy_o && cyc < 200) begin
      tick();
      cyc++;
    end
    check("flush2_done", flush_busy_o, 0);
    @(negedge clk_i);
    check("busy_write_absent", hit_o, 0);
    tick();

    // Reset in the middle of an emit aborts the flush and clears the arrays.
    drive(1, 1, 9, {2'b11, 23'h99}, rand_line());
    tick();
    drive(0, 0, 9, {2'b11, 23'h99}, '0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    cyc = 0;
    while (!flush_valid_o && cyc < 200) begin
      tick();
      cyc++;
    end
    check("emit_reached", flush_valid_o, 1);
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("abort_busy", flush_busy_o, 0);
    check("abort_valid", flush_valid_o, 0);
    check("abort_miss", hit_o, 0);
    check("abort_victim", victim_data_o, '0);
    tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      logic [TAG_W-1:0] t;
      int s;
      s = ($urandom_range(0, 7) == 0) ? $urandom_range(0, SETS - 1) : $urandom_range(0, 3);
      t = {($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)),
           23'($urandom_range(0, 5))};
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, s, t, rand_line());
      flush_i       = ($urandom_range(0, 199) == 0);
      flush_ready_i = 1'($urandom_range(0, 1));
      tick();
    end
    drive(0, 0, 0, '0, '0);
    flush_i = 1'b0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
